vga_timing_gen: RTL and testbench

Raster timing stage directly downstream of the APB pixel-write path. It generates 640x480@60 Hz VGA sync from the system clock via a pixel-enable divider, and publishes the current scan coordinates so the framebuffer can be read. It then realigns the sync and blanking outputs to the framebuffer read latency and blanks the returned pixel colour outside the visible region.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_align_dly.sv | 35 +++
 rtl/vga_timing_gen.sv | 134 +++++++++++++
 tb/tb_vga_timing_gen.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 timing defaults for the VGA raster stage.
// Imported by the timing generator, its interface and the bench.
package vga_pkg;

  typedef logic [10:0] coord_t;
  typedef logic [11:0] rgb_t;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_FB_LAT   = 1;

  localparam int unsigned H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_win(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Framebuffer read bus: pixel tick, scan coordinates, read strobe, colour.
// master = timing generator, slave = framebuffer.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pix_en_o;
  coord_t pix_x_o;
  coord_t pix_y_o;
  logic   rd_req_o;
  rgb_t   rgb_i;

  modport master (
    output pix_en_o, pix_x_o, pix_y_o, rd_req_o,
    input  rgb_i
  );

  modport slave (
    input  pix_en_o, pix_x_o, pix_y_o, rd_req_o,
    output rgb_i
  );

endinterface

// File: rtl/vga_align_dly.sv
// DEPTH-stage register chain (DEPTH=0 is a wire), sync reset to RST_VAL.
// Ports: clk_i, rst_i, i_d (W bits in), o_q (W bits out).
module vga_align_dly #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = clk_i ^ rst_i;
    assign o_q = i_d;
  end else begin : g_chain
    logic [W-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(DEPTH); i++)
          r_pipe[i] <= RST_VAL;
      end else begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < int'(DEPTH); i++)
          r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_q = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, x/y scan counters, sync/blank
// realigned to framebuffer latency. Ports: clk_i, rst_i, fb (read bus),
// frame_start_o, vga_hs_o, vga_vs_o, active_o, rgb_o.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned FB_LAT   = DEF_FB_LAT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vga_timing_gen_if.master fb,
  output logic             frame_start_o,
  output logic             vga_hs_o,
  output logic             vga_vs_o,
  output logic             active_o,
  output rgb_t             rgb_o
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end
  if (FB_LAT > 4) begin : g_bad_lat
    $error("FB_LAT must be in 0..4");
  end
  if (H_TOT >= 2048 || V_TOT >= 2048) begin : g_bad_tot
    $error("timing totals must fit 11-bit counters");
  end

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam coord_t H_MAX = coord_t'(H_TOT - 1);
  localparam coord_t V_MAX = coord_t'(V_TOT - 1);
  localparam coord_t HA_C  = coord_t'(H_ACTIVE);
  localparam coord_t VA_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_LO = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic ON  = SYNC_POL;
  localparam logic OFF = ~SYNC_POL;

  logic [DW-1:0] r_div;
  coord_t        r_x;
  coord_t        r_y;
  logic          w_tick;
  logic          w_pix_en;
  logic          w_vis;
  logic          w_hs_raw;
  logic          w_vs_raw;
  logic [2:0]    w_dly;
  logic          r_hs;
  logic          r_vs;
  logic          r_act;
  rgb_t          r_rgb;

  assign w_tick = (r_div == DIV_MAX);
  // Gated so the tick stays low while reset is held even when CLK_DIV=1.
  assign w_pix_en = w_tick & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      if (r_x == H_MAX) begin
        r_x <= '0;
        r_y <= (r_y == V_MAX) ? '0 : r_y + 11'd1;
      end else begin
        r_x <= r_x + 11'd1;
      end
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign w_vis    = (r_x < HA_C) && (r_y < VA_C);
  assign w_hs_raw = in_win(r_x, HS_LO, HS_HI) ? ON : OFF;
  assign w_vs_raw = in_win(r_y, VS_LO, VS_HI) ? ON : OFF;

  // FB_LAT stages here line the active flag up with returning rgb_i.
  vga_align_dly #(
    .DEPTH   (FB_LAT),
    .W       (3),
    .RST_VAL ({OFF, OFF, 1'b0})
  ) u_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_d   ({w_hs_raw, w_vs_raw, w_vis}),
    .o_q   (w_dly)
  );

  // Final stage shared by sync, active and colour so all move together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hs  <= OFF;
      r_vs  <= OFF;
      r_act <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hs  <= w_dly[2];
      r_vs  <= w_dly[1];
      r_act <= w_dly[0];
      r_rgb <= w_dly[0] ? fb.rgb_i : '0;
    end
  end

  assign fb.pix_en_o  = w_pix_en;
  assign fb.pix_x_o   = r_x;
  assign fb.pix_y_o   = r_y;
  assign fb.rd_req_o  = w_pix_en & w_vis;
  assign frame_start_o = w_pix_en & (r_x == '0) & (r_y == '0);
  assign vga_hs_o     = r_hs;
  assign vga_vs_o     = r_vs;
  assign active_o     = r_act;
  assign rgb_o        = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: cycle-count reference model, queued
// expectations, negedge monitors over several parameter sets.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int cd, fl, pol;
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
  } cfg_t;

  typedef struct packed {
    logic   pe;
    coord_t x;
    coord_t y;
    logic   rd;
    logic   fs;
    logic   hs;
    logic   vs;
    logic   act;
    rgb_t   rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Expected outputs c clocks after the most recent reset edge.
  function automatic exp_t model(cfg_t p, int c, bit rn, rgb_t prev);
    exp_t e;
    int ht, vt, k, x, y, dk, dx, dy;
    bit idle;
    ht = p.ha + p.hf + p.hs + p.hb;
    vt = p.va + p.vf + p.vs + p.vb;
    idle = (p.pol == 0);
    k = c / p.cd;
    x = k % ht;
    y = (k / ht) % vt;
    e.pe = !rn && (c % p.cd == p.cd - 1);
    e.x = coord_t'(x);
    e.y = coord_t'(y);
    e.rd = e.pe && x < p.ha && y < p.va;
    e.fs = e.pe && x == 0 && y == 0;
    e.hs = idle;
    e.vs = idle;
    e.act = 1'b0;
    e.rgb = '0;
    if (c >= p.fl + 1) begin
      dk = (c - p.fl - 1) / p.cd;
      dx = dk % ht;
      dy = (dk / ht) % vt;
      e.act = dx < p.ha && dy < p.va;
      if (dx >= p.ha + p.hf && dx < p.ha + p.hf + p.hs)
        e.hs = !idle;
      if (dy >= p.va + p.vf && dy < p.va + p.vf + p.vs)
        e.vs = !idle;
      e.rgb = e.act ? prev : '0;
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input exp_t a);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s t=%0t got pe=%b x=%0d y=%0d rd=%b fs=%b hs=%b vs=%b act=%b rgb=%h want pe=%b x=%0d y=%0d rd=%b fs=%b hs=%b vs=%b act=%b rgb=%h",
        nm, $time, a.pe, a.x, a.y, a.rd, a.fs, a.hs, a.vs, a.act, a.rgb,
        e.pe, e.x, e.y, e.rd, e.fs, e.hs, e.vs, e.act, e.rgb);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Reduced-size timings keep several full frames within the run.
  localparam int P_CD [4] = '{4, 2, 3, 1};
  localparam int P_FL [4] = '{1, 0, 3, 2};
  localparam int P_PO [4] = '{0, 0, 0, 1};
  localparam int P_HA [4] = '{16, 16, 12, 16};
  localparam int P_HF [4] = '{2, 2, 3, 2};
  localparam int P_HS [4] = '{4, 4, 2, 4};
  localparam int P_HB [4] = '{3, 3, 2, 3};
  localparam int P_VA [4] = '{6, 6, 5, 6};
  localparam int P_VF [4] = '{1, 1, 2, 1};
  localparam int P_VS [4] = '{2, 2, 1, 2};
  localparam int P_VB [4] = '{1, 1, 2, 1};

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int CD = P_CD[g];
    localparam int FL = P_FL[g];
    localparam int PO = P_PO[g];

    vga_timing_gen_if fb();
    logic fs, hs, vs, act;
    rgb_t rgb;
    exp_t q[$];

    vga_timing_gen #(
      .CLK_DIV  (CD),
      .H_ACTIVE (P_HA[g]), .H_FP (P_HF[g]),
      .H_SYNC   (P_HS[g]), .H_BP (P_HB[g]),
      .V_ACTIVE (P_VA[g]), .V_FP (P_VF[g]),
      .V_SYNC   (P_VS[g]), .V_BP (P_VB[g]),
      .SYNC_POL (PO[0]),
      .FB_LAT   (FL)
    ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .fb            (fb),
      .frame_start_o (fs),
      .vga_hs_o      (hs),
      .vga_vs_o      (vs),
      .active_o      (act),
      .rgb_o         (rgb)
    );

    initial begin : drv
      cfg_t p;
      int c;
      bit live, rs;
      exp_t e;
      p.cd = CD; p.fl = FL; p.pol = PO;
      p.ha = P_HA[g]; p.hf = P_HF[g]; p.hs = P_HS[g]; p.hb = P_HB[g];
      p.va = P_VA[g]; p.vf = P_VF[g]; p.vs = P_VS[g]; p.vb = P_VB[g];
      c = 0;
      live = 1'b0;
      fb.rgb_i = '0;
      forever begin
        @(posedge clk);
        rs = rst_i;
        #2;
        if (rs) begin
          c = 0;
          live = 1'b1;
        end else begin
          c++;
        end
        if (live) begin
          e = model(p, c, rst_i, fb.rgb_i);
          q.push_back(e);
        end
        fb.rgb_i = rgb_t'($urandom);
      end
    end

    initial begin : mon
      exp_t e, a;
      forever begin
        @(negedge clk);
        if (q.size() != 0) begin
          e = q.pop_front();
          a.pe = fb.pix_en_o; a.x = fb.pix_x_o; a.y = fb.pix_y_o;
          a.rd = fb.rd_req_o; a.fs = fs; a.hs = hs; a.vs = vs;
          a.act = act; a.rgb = rgb;
          cmp($sformatf("inst%0d", g), e, a);
        end
      end
    end
  end

  // Full-size 640x480 instance with default parameters.
  vga_timing_gen_if fb_d();
  logic d_fs, d_hs, d_vs, d_act;
  rgb_t d_rgb;
  exp_t qd[$];

  vga_timing_gen dut_d (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .fb            (fb_d),
    .frame_start_o (d_fs),
    .vga_hs_o      (d_hs),
    .vga_vs_o      (d_vs),
    .active_o      (d_act),
    .rgb_o         (d_rgb)
  );

  initial begin : drv_d
    cfg_t p;
    int c;
    bit live, rs;
    exp_t e;
    p.cd = 4; p.fl = 1; p.pol = 0;
    p.ha = 640; p.hf = 16; p.hs = 96; p.hb = 48;
    p.va = 480; p.vf = 10; p.vs = 2; p.vb = 33;
    c = 0;
    live = 1'b0;
    fb_d.rgb_i = '0;
    forever begin
      @(posedge clk);
      rs = rst_i;
      #2;
      if (rs) begin
        c = 0;
        live = 1'b1;
      end else begin
        c++;
      end
      if (live) begin
        e = model(p, c, rst_i, fb_d.rgb_i);
        qd.push_back(e);
      end
      fb_d.rgb_i = rgb_t'($urandom);
    end
  end

  initial begin : mon_d
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (qd.size() != 0) begin
        e = qd.pop_front();
        a.pe = fb_d.pix_en_o; a.x = fb_d.pix_x_o; a.y = fb_d.pix_y_o;
        a.rd = fb_d.rd_req_o; a.fs = d_fs; a.hs = d_hs; a.vs = d_vs;
        a.act = d_act; a.rgb = d_rgb;
        cmp("dflt", e, a);
      end
    end
  end

  initial begin : main
    int hs_low;
    int n;
    repeat (4) @(posedge clk);
    #1 rst_i = 1'b0;

    hs_low = 0;
    repeat (3300) begin
      @(negedge clk);
      if (d_hs == 1'b0) hs_low++;
    end
    chk_int("dflt_hs_low_clks", hs_low, 384);
    repeat (1700) @(posedge clk);

    @(posedge clk);
    #1 rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (2500) @(posedge clk);

    n = $urandom_range(1, 5);
    @(posedge clk);
    #1 rst_i = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (2500) @(posedge clk);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
